add_serial_feeder: RTL and testbench
====================================

# add_serial_feeder

- Upstream issue stage for the serial adder.
- Buffers operand pairs in a small FIFO behind a valid/ready handshake.
- Issues each pair to the adder with a one-cycle `en` pulse, holding `a`/`b` stable while the addition runs.
- Waits a fixed latency, captures the adder's 8-bit result, and presents it downstream with a valid/ready handshake.
- Exactly one addition is in flight at any time.

## Interface
Parameters:
- `DEPTH`, 4: operand FIFO entries; power of two, ≥2.
- `ADD_LAT`, 10: cycles from the `en` cycle to the cycle whose closing edge samples `sum_in`; ≥1.

Ports:
- `clk`  input  1  — single clock; all logic on rising edge.
- `rst`  input  1  — reset; synchronous, active-high.
- `in_valid`  input  1  — operand pair valid.
- `in_ready`  output  1  — FIFO can accept.
- `in_a`  input  8  — operand A.
- `in_b`  input  8  — operand B.
- `en`  output  1  — start pulse to the adder.
- `a`  output  8  — operand A to the adder.
- `b`  output  8  — operand B to the adder.
- `sum_in`  input  8  — adder result (`out` of the adder).
- `res_valid`  output  1  — result available.
- `res_ready`  input  1  — downstream accepts result.
- `res_sum`  output  8  — captured result.
- `occ`  output  log2(DEPTH)+1  — FIFO occupancy, 0..DEPTH.

## Operation
- **Reset:** all outputs registered and cleared to 0, except `in_ready`=1. State=IDLE, FIFO empty, pointers 0, latency counter 0.
- **FIFO:**
  - Push when `in_valid && in_ready`. `in_ready = (occ != DEPTH)`, from registered occupancy only; no bypass when full.
  - Pop happens only in ISSUE. Push and pop in the same cycle leave `occ` unchanged.
  - Read/write pointers wrap modulo DEPTH.
- **FSM states:** IDLE, ISSUE, WAIT, HOLD.
  - **IDLE:** if `occ != 0` → ISSUE; else stay.
  - **ISSUE:**
    - `en`=1 this cycle only.
    - `a`/`b` = head entry, registered so they are valid during this cycle.
    - Pop the head; load counter with ADD_LAT-1; → WAIT.
  - **WAIT:**
    - `a`/`b` hold; `en`=0.
    - Counter decrements each cycle.
    - When counter==0: capture `sum_in` into `res_sum`, set `res_valid`, → HOLD.
  - **HOLD:**
    - `res_valid`=1; `res_sum` stable.
    - On `res_ready`=1: clear `res_valid` → IDLE.
    - Otherwise stay; no new issue while holding.
- `a`/`b` keep the last issued operands until the next ISSUE. They are never changed outside ISSUE.
- Results come out in push order; there is no reordering or dropping.
- `res_sum` is taken verbatim, 8 bits. The carry-out is not observed; overflow wraps modulo 256 by definition.
- `rst` in any state:
  - Returns the block to reset values next edge.
  - The in-flight result is discarded and FIFO contents are lost.
  - The adder shares `rst`.

## Timing
- Push at edge ending cycle t → `occ` updates in cycle t+1.
- FSM in IDLE at t+1 → ISSUE at cycle E=t+2 (`en` high).
- `sum_in` sampled at edge ending cycle E+ADD_LAT; `res_valid` high from cycle E+ADD_LAT+1.
- With `res_ready` tied 1: HOLD lasts 1 cycle, then IDLE at E+ADD_LAT+2, next ISSUE at E+ADD_LAT+3. Steady-state period is ADD_LAT+3 cycles per operation.
- `in_ready` drops in the cycle after the push that makes `occ`=DEPTH. It rises in the cycle after the ISSUE pop.
- Simultaneous push and ISSUE pop when full cannot occur, since `in_ready`=0.
- `res_valid` and `res_sum` hold unchanged through any number of `res_ready`=0 cycles.

## Test plan
- **Reset:** hold `rst` 3 cycles with random inputs.
  - Required: `en`=0, `a`=`b`=0, `res_valid`=0, `res_sum`=0, `occ`=0, `in_ready`=1.
  - Release: no `en` while idle.
- **Single op:** push a=0x23, b=0x14 at cycle 0; behavioural adder model drives `sum_in`.
  - Required: `en`=1 only at cycle 2 with `a`=0x23, `b`=0x14.
  - Required: `res_valid`=1 at cycle 13 with `res_sum`=0x37.
- **Wrap sum:** push 0xF0 + 0x25.
  - Required: `res_sum`=0x15, `en` single pulse.
- **Full FIFO:** `res_ready`=0, offer 6 pairs back-to-back.
  - Required: first pair issued, then 4 more accepted (`occ`=4).
  - Required: `in_ready`=0 holds the 6th until HOLD clears.
  - Required: `occ` never exceeds 4.
- **Backpressure and ordering:** stream 10 pairs (i, 2i), randomly toggle `res_ready`.
  - Required: results 3i in order, pointers wrap twice.
  - Required: `res_sum` stable while `res_valid && !res_ready`.
  - Required: exactly 10 `en` pulses.
- **Reset mid-WAIT:** assert `rst` at cycle E+4 with 2 entries queued.
  - Required: next cycle state IDLE, `occ`=0, `res_valid`=0.
  - Required: no stale result appears; the next push issues normally.

Source files
------------

// File: rtl/add_serial_feeder.sv
// add_serial_feeder: issue stage in front of the serial adder.
// Operand pairs queue in a small FIFO. One pair at a time is sent to the
// adder with a single-cycle en pulse. After a fixed latency the 8-bit sum is
// captured and offered downstream behind a valid/ready handshake.

module add_serial_feeder #(
    parameter int DEPTH   = 4,
    parameter int ADD_LAT = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_a,
    input  logic [7:0]               in_b,
    output logic                     en,
    output logic [7:0]               a,
    output logic [7:0]               b,
    input  logic [7:0]               sum_in,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [7:0]               res_sum,
    output logic [$clog2(DEPTH):0]   occ
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ADD_LAT - 1);
    localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t state, state_n;

    logic [7:0]       mem_a [DEPTH];
    logic [7:0]       mem_b [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   occ_n;
    logic [CNT_W-1:0] lat_cnt;

    logic push;
    logic do_issue;
    logic do_pop;
    logic do_capture;
    logic do_drain;

    // in_ready is the registered "not full" flag, so a full FIFO never
    // accepts even when the same cycle pops.
    assign push = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic and one-cycle control strobes.
    always_comb begin
        state_n    = state;
        do_issue   = 1'b0;
        do_pop     = 1'b0;
        do_capture = 1'b0;
        do_drain   = 1'b0;
        case (state)
            IDLE: begin
                if (occ != '0) begin
                    do_issue = 1'b1;
                    state_n  = ISSUE;
                end
            end
            ISSUE: begin
                do_pop  = 1'b1;
                state_n = WAIT;
            end
            WAIT: begin
                if (lat_cnt == '0) begin
                    do_capture = 1'b1;
                    state_n    = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    do_drain = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Occupancy after this cycle's push/pop; a simultaneous push and pop cancel.
    always_comb begin
        occ_n = occ;
        case ({push, do_pop})
            2'b10:   occ_n = occ + 1'b1;
            2'b01:   occ_n = occ - 1'b1;
            default: occ_n = occ;
        endcase
    end

    // FIFO storage; contents need no reset because occ gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    // FIFO pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            in_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            occ      <= occ_n;
            in_ready <= (occ_n != OCC_FULL);
        end
    end

    // Issue registers: operands load on entry to ISSUE and then hold until
    // the next issue; en is high for the ISSUE cycle only.
    always_ff @(posedge clk) begin
        if (rst) begin
            en <= 1'b0;
            a  <= '0;
            b  <= '0;
        end else begin
            en <= do_issue;
            if (do_issue) begin
                a <= mem_a[rd_ptr];
                b <= mem_b[rd_ptr];
            end
        end
    end

    // Latency counter: loaded in ISSUE, counts down through WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt <= '0;
        end else if (state == ISSUE) begin
            lat_cnt <= CNT_LOAD;
        end else if (state == WAIT && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
        end
    end

    // Result capture and downstream handshake; the sum wraps modulo 256.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_sum   <= '0;
        end else begin
            if (do_capture) begin
                res_sum   <= sum_in;
                res_valid <= 1'b1;
            end else if (do_drain) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_add_serial_feeder.sv
// Testbench for add_serial_feeder: directed operand pairs with hand-computed
// sums, a behavioural fixed-latency adder, and a scoreboard monitor.

module tb_add_serial_feeder;

    localparam int DEPTH   = 4;
    localparam int ADD_LAT = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;
    logic       en;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum_in;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [7:0] res_sum;
    logic [$clog2(DEPTH):0] occ;

    add_serial_feeder #(.DEPTH(DEPTH), .ADD_LAT(ADD_LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .en(en), .a(a), .b(b), .sum_in(sum_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
        .occ(occ)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural adder: the sum only becomes correct ADD_LAT cycles after en.
    int add_cnt = 0;
    always @(posedge clk) begin
        if (rst) add_cnt <= 0;
        else if (en) add_cnt <= 1;
        else if (add_cnt != 0 && add_cnt < 1000) add_cnt <= add_cnt + 1;
    end
    always_comb begin
        sum_in = 8'h00;
        if (add_cnt >= ADD_LAT) sum_in = a + b;
        else sum_in = (a + b) ^ 8'h5A;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard queues, filled when a push is accepted.
    logic [7:0] exp_sum_q[$];
    logic [7:0] exp_a_q[$];
    logic [7:0] exp_b_q[$];

    int en_cnt = 0;
    int last_en_cyc = -1;
    int last_rv_cyc = -1;
    int accepted = 0;
    int push_cyc = 0;

    logic       prev_en = 1'b0;
    logic       prev_rv = 1'b0;
    logic       hold_pend = 1'b0;
    logic [7:0] held_sum = 8'h00;
    logic [7:0] cur_a = 8'h00;
    logic [7:0] cur_b = 8'h00;

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_en   = 1'b0;
            prev_rv   = 1'b0;
            hold_pend = 1'b0;
            cur_a     = 8'h00;
            cur_b     = 8'h00;
        end else begin
            check("occ_bound", 32'(occ <= DEPTH), 1);
            if (en) begin
                en_cnt++;
                last_en_cyc = cyc;
                check("en_single_pulse", 32'(prev_en), 0);
                if (exp_a_q.size() == 0) begin
                    check("en_unexpected", 1, 0);
                end else begin
                    check("issue_a", 32'(a), 32'(exp_a_q.pop_front()));
                    check("issue_b", 32'(b), 32'(exp_b_q.pop_front()));
                end
                cur_a = a;
                cur_b = b;
            end else begin
                check("a_stable", 32'(a), 32'(cur_a));
                check("b_stable", 32'(b), 32'(cur_b));
            end
            if (res_valid && !prev_rv) last_rv_cyc = cyc;
            if (hold_pend) begin
                check("hold_valid", 32'(res_valid), 1);
                check("hold_sum", 32'(res_sum), 32'(held_sum));
            end
            if (res_valid && res_ready) begin
                if (exp_sum_q.size() == 0) check("res_unexpected", 1, 0);
                else check("res_sum", 32'(res_sum), 32'(exp_sum_q.pop_front()));
            end
            hold_pend = res_valid && !res_ready;
            held_sum  = res_sum;
            prev_en   = en;
            prev_rv   = res_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one pair; it is accepted at the end of the first cycle with in_ready high.
    task automatic push(input logic [7:0] pa, input logic [7:0] pb, input logic [7:0] ps);
        int n = 0;
        in_valid = 1'b1;
        in_a = pa;
        in_b = pb;
        while (!in_ready && n < 300) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            check("push_timeout", 0, 1);
        end else begin
            exp_a_q.push_back(pa);
            exp_b_q.push_back(pb);
            exp_sum_q.push_back(ps);
            accepted++;
            push_cyc = cyc;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_sum_q.size() != 0 && n < 800) begin
            tick();
            n++;
        end
        check("drain_empty", 32'(exp_sum_q.size()), 0);
        repeat (2) tick();
    endtask

    initial begin
        int en0;
        int acc0;
        int pc;
        int rv_seen;
        bit pushes_done;

        // Reset with random inputs.
        tick();
        repeat (3) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            res_ready = 1'($urandom_range(0, 1));
            check("rst_en", 32'(en), 0);
            check("rst_a", 32'(a), 0);
            check("rst_b", 32'(b), 0);
            check("rst_res_valid", 32'(res_valid), 0);
            check("rst_res_sum", 32'(res_sum), 0);
            check("rst_occ", 32'(occ), 0);
            check("rst_in_ready", 32'(in_ready), 1);
            tick();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        res_ready = 1'b1;
        repeat (6) tick();
        check("idle_no_en", 32'(en_cnt), 0);

        // Single op: en at push+2, result valid at push+13.
        en0 = en_cnt;
        push(8'h23, 8'h14, 8'h37);
        pc = push_cyc;
        repeat (20) tick();
        check("single_en_cycle", 32'(last_en_cyc - pc), 2);
        check("single_rv_cycle", 32'(last_rv_cyc - pc), 13);
        check("single_en_count", 32'(en_cnt - en0), 1);
        drain();

        // Wrapping sum.
        en0 = en_cnt;
        push(8'hF0, 8'h25, 8'h15);
        drain();
        check("wrap_en_count", 32'(en_cnt - en0), 1);

        // Full FIFO under held result.
        res_ready = 1'b0;
        acc0 = accepted;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    push(8'(i + 1), 8'h10, 8'(i + 8'h11));
            end
            begin
                repeat (25) tick();
                check("full_occ", 32'(occ), 4);
                check("full_in_ready", 32'(in_ready), 0);
                check("full_accepted", 32'(accepted - acc0), 5);
                check("full_res_valid", 32'(res_valid), 1);
                res_ready = 1'b1;
            end
        join
        drain();
        check("full_all_accepted", 32'(accepted - acc0), 6);

        // Stream with random backpressure.
        en0 = en_cnt;
        pushes_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    push(8'(i), 8'(2 * i), 8'(3 * i));
                pushes_done = 1'b1;
            end
            begin
                int n = 0;
                while ((!pushes_done || exp_sum_q.size() != 0) && n < 3000) begin
                    res_ready = 1'($urandom_range(0, 1));
                    tick();
                    n++;
                end
            end
        join
        res_ready = 1'b1;
        drain();
        check("stream_en_count", 32'(en_cnt - en0), 10);

        // Reset while waiting on the adder with two entries queued.
        en0 = en_cnt;
        push(8'h01, 8'h02, 8'h03);
        pc = push_cyc;
        push(8'h04, 8'h05, 8'h09);
        push(8'h06, 8'h07, 8'h0D);
        while (cyc < pc + 6) tick();
        check("midwait_occ", 32'(occ), 2);
        rst = 1'b1;
        exp_sum_q.delete();
        exp_a_q.delete();
        exp_b_q.delete();
        tick();
        rst = 1'b0;
        check("postrst_occ", 32'(occ), 0);
        check("postrst_res_valid", 32'(res_valid), 0);
        check("postrst_en", 32'(en), 0);
        check("postrst_in_ready", 32'(in_ready), 1);
        en0 = en_cnt;
        rv_seen = 0;
        repeat (25) begin
            tick();
            if (res_valid) rv_seen++;
        end
        check("postrst_no_en", 32'(en_cnt - en0), 0);
        check("postrst_no_result", 32'(rv_seen), 0);
        push(8'h40, 8'h02, 8'h42);
        drain();
        check("postrst_issue", 32'(en_cnt - en0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
